// File: rtl/ex_operand_stage_pkg.sv
// Shared CPU types for the execute-stage front end: ALU op codes, register
// constants and the ID/EX register record.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [2:0] {
    ALU_MOV = 3'b000,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110
  } alu_op_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              set_flags;
    logic              use_imm;
    alu_op_t           alu_cntrl;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rm;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rn_data;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  // A bubble points every index at XZR so the forwarding muxes yield zero.
  function automatic id_ex_t bubble();
    id_ex_t b;
    b           = '0;
    b.alu_cntrl = ALU_MOV;
    b.rn        = ZERO_REG;
    b.rm        = ZERO_REG;
    b.rd        = ZERO_REG;
    return b;
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode, forwarding-source and ALU-operand signals of the ID/EX stage.
// The stage itself uses the slave modport; whoever drives decode uses master.
interface ex_operand_stage_if;
  import cpu_pkg::*;

  logic              stall_in;
  logic              flush;
  logic              dec_valid;
  logic [REG_W-1:0]  dec_rn;
  logic [REG_W-1:0]  dec_rm;
  logic [REG_W-1:0]  dec_rd;
  logic [DATA_W-1:0] dec_rn_data;
  logic [DATA_W-1:0] dec_rm_data;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_use_imm;
  logic [2:0]        dec_alu_cntrl;
  logic              dec_reg_write;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              dec_set_flags;
  logic              mem_reg_write;
  logic              wb_reg_write;
  logic [REG_W-1:0]  mem_rd;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_cntrl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_set_flags;
  logic              ex_valid;
  logic              load_use_stall;

  modport master (
    output stall_in, flush, dec_valid, dec_rn, dec_rm, dec_rd, dec_rn_data,
           dec_rm_data, dec_imm, dec_use_imm, dec_alu_cntrl, dec_reg_write,
           dec_mem_read, dec_mem_write, dec_set_flags, mem_reg_write,
           wb_reg_write, mem_rd, wb_rd, mem_data, wb_data,
    input  alu_a, alu_b, alu_cntrl, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_set_flags, ex_valid, load_use_stall
  );

  modport slave (
    input  stall_in, flush, dec_valid, dec_rn, dec_rm, dec_rd, dec_rn_data,
           dec_rm_data, dec_imm, dec_use_imm, dec_alu_cntrl, dec_reg_write,
           dec_mem_read, dec_mem_write, dec_set_flags, mem_reg_write,
           wb_reg_write, mem_rd, wb_rd, mem_data, wb_data,
    output alu_a, alu_b, alu_cntrl, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_set_flags, ex_valid, load_use_stall
  );

endinterface

// File: rtl/ex_operand_stage_fwd_select.sv
// Operand forwarding mux for one source register: XZR, then EX/MEM, then
// MEM/WB, then the value read from the register file at decode.
module fwd_select
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);

  always_comb begin
    operand = reg_data;
    if (idx == ZERO_REG) begin
      operand = '0;
    end else if (mem_reg_write && (mem_rd == idx)) begin
      operand = mem_data;
    end else if (wb_reg_write && (wb_rd == idx)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding into the ALU operands and
// load-use hazard detection that bubbles EX and stalls fetch/decode.
module ex_operand_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ex_operand_stage_if.slave  bus
);

  id_ex_t            q;
  id_ex_t            captured;
  logic [DATA_W-1:0] rn_fwd;
  logic [DATA_W-1:0] rm_fwd;
  logic              rm_is_read;

  // The rm field only matters to a following load when it is a real operand
  // or the data of a store; an immediate-form ALU op ignores it.
  assign rm_is_read = !bus.dec_use_imm || bus.dec_mem_write;

  assign bus.load_use_stall = q.valid && q.mem_read && (q.rd != ZERO_REG) &&
                              bus.dec_valid &&
                              ((q.rd == bus.dec_rn) ||
                               ((q.rd == bus.dec_rm) && rm_is_read));

  always_comb begin
    captured           = bubble();
    captured.valid     = bus.dec_valid;
    captured.reg_write = bus.dec_reg_write & bus.dec_valid;
    captured.mem_read  = bus.dec_mem_read  & bus.dec_valid;
    captured.mem_write = bus.dec_mem_write & bus.dec_valid;
    captured.set_flags = bus.dec_set_flags & bus.dec_valid;
    captured.use_imm   = bus.dec_use_imm;
    captured.alu_cntrl = alu_op_t'(bus.dec_alu_cntrl);
    captured.rn        = bus.dec_rn;
    captured.rm        = bus.dec_rm;
    captured.rd        = bus.dec_rd;
    captured.rn_data   = bus.dec_rn_data;
    captured.rm_data   = bus.dec_rm_data;
    captured.imm       = bus.dec_imm;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= bubble();
    end else if (bus.flush) begin
      q <= bubble();
    end else if (bus.stall_in) begin
      q <= q;
    end else if (bus.load_use_stall) begin
      q <= bubble();
    end else begin
      q <= captured;
    end
  end

  fwd_select u_fwd_rn (
    .idx           (q.rn),
    .reg_data      (q.rn_data),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .operand       (rn_fwd)
  );

  fwd_select u_fwd_rm (
    .idx           (q.rm),
    .reg_data      (q.rm_data),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .operand       (rm_fwd)
  );

  assign bus.alu_a         = rn_fwd;
  assign bus.alu_b         = q.use_imm ? q.imm : rm_fwd;
  assign bus.ex_store_data = rm_fwd;
  assign bus.alu_cntrl     = q.alu_cntrl;
  assign bus.ex_rd         = q.rd;
  assign bus.ex_reg_write  = q.reg_write;
  assign bus.ex_mem_read   = q.mem_read;
  assign bus.ex_mem_write  = q.mem_write;
  assign bus.ex_set_flags  = q.set_flags;
  assign bus.ex_valid      = q.valid;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding front end for the 64-bit execute-stage ALU.
- Latches decoded operands and control, then drives the ALU A/B inputs and 3-bit op code.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts a bubble while requesting an upstream stall.

Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register index width
- ZERO_REG, 31, index of XZR; always reads 0, never forwarded

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high reset
- stall_in  input  1  global hold (e.g. memory wait); freezes register contents
- flush  input  1  squash: load a bubble into EX
- dec_valid  input  1  decode slot holds a real instruction
- dec_rn, dec_rm, dec_rd  input  REG_W  source 1, source 2 / store register, destination
- dec_rn_data, dec_rm_data  input  DATA_W  register-file read data
- dec_imm  input  DATA_W  sign/zero-extended immediate
- dec_use_imm  input  1  B operand comes from the immediate
- dec_alu_cntrl  input  3  ALU op: 000 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR
- dec_reg_write, dec_mem_read, dec_mem_write, dec_set_flags  input  1 each  control bits
- mem_reg_write, wb_reg_write  input  1 each  forwarding-source write enables
- mem_rd, wb_rd  input  REG_W  forwarding-source destinations
- mem_data, wb_data  input  DATA_W  forwarding-source values
- alu_a, alu_b  output  DATA_W  ALU operands (forwarded)
- alu_cntrl  output  3  registered op code
- ex_store_data  output  DATA_W  forwarded rm value for stores
- ex_rd  output  REG_W  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_set_flags, ex_valid  output  1 each  registered control bits
- load_use_stall  output  1  combinational request to hold fetch/decode

Behaviour:
- Register update priority on each clk edge: reset > flush > stall_in > load_use_stall > capture.
- Reset:
  - all control bits 0; ex_valid 0; alu_cntrl 000.
  - stored rn/rm/rd = ZERO_REG; stored data and immediate 0; use_imm 0.
  - Result: alu_a = alu_b = ex_store_data = 0 and load_use_stall = 0, whatever the forwarding inputs.
- Flush: loads a bubble with the same contents as the reset state. Flush wins over stall_in.
- stall_in: every stored field holds its value. Outputs may still change through forwarding muxes as mem/wb inputs change.
- load_use_stall:
  - Asserted when ex_valid & ex_mem_read & ex_rd != ZERO_REG & dec_valid & (ex_rd == dec_rn | (ex_rd == dec_rm & (!dec_use_imm | dec_mem_write))).
  - When asserted and not stall_in, load a bubble on the next edge. Upstream holds decode, so the instruction is retried one cycle later.
- Capture: all dec_* fields are registered; ex_valid = dec_valid. Control bits are ANDed with dec_valid.
- Forwarding (combinational from registered index) for operand X ∈ {rn, rm}:
  - X_q == ZERO_REG → 0
  - else mem_reg_write & mem_rd == X_q → mem_data (EX/MEM has priority over MEM/WB)
  - else wb_reg_write & wb_rd == X_q → wb_data
  - else stored register data
- Operand outputs:
  - alu_a = forwarded rn.
  - alu_b = use_imm_q ? imm_q : forwarded rm.
  - ex_store_data = forwarded rm, always, independent of use_imm_q.
- Latency: one cycle from decode to EX outputs. Forwarding adds zero cycles.
- No arithmetic inside the block. Widths pass through unchanged.

Decomposition:
- Shared package cpu_pkg: alu_op_t enum (MOV, ADD, SUB, AND, OR, XOR with the codes above), ZERO_REG constant, and an id_ex_t struct bundling registered fields.
- One sub-module, fwd_select (index, stored data, mem/wb sources → operand), instantiated twice.

Test Plan:
- Reset with mem_reg_write=1, mem_rd=31, mem_data=0x55 driven: ex_valid=0, alu_a=alu_b=0, alu_cntrl=000, load_use_stall=0.
- Forwarding priority: capture ADD rn=1, rm=2, rn_data=5, rm_data=7. Drive mem_rd=1 mem_data=100 and wb_rd=1 wb_data=200 → alu_a=100, alu_b=7. Drop mem_reg_write → alu_a=200. Drop both → alu_a=5.
- XZR: capture rn=31 with mem_rd=31, mem_reg_write=1, mem_data=0x55 → alu_a=0.
- Load-use: EX holds LDUR rd=3 (mem_read=1); decode ADD rn=3 → load_use_stall=1. Next cycle ex_valid=0, ex_reg_write=0. Decode ADDI rm=3, use_imm=1 → stall=0. Decode STUR rm=3 → stall=1.
- Immediate/store: capture use_imm=1, imm=0x10, rm=4, mem_write=1 with mem_rd=4 mem_data=0x99 → alu_b=0x10, ex_store_data=0x99.
- Hold/flush: stall_in=1 for 2 cycles while dec_* change → registered outputs unchanged. flush=1 together with stall_in=1 → next cycle ex_valid=0, ex_mem_write=0.
